// File: rtl/dot_accumulator.sv
// -----------------------------------------------------------------------------
// dot_accumulator
//
// Sums a run of LEN signed Q17.15 products (one row-times-column dot product)
// into a single Q17.15 result. Products arrive on a valid/ready handshake.
// The result is held on a valid/ready output until the consumer accepts it.
//
// Optional feature macro: DOT_ACC_SAT_EN
//   defined   : the final narrowing clamps to the WIDTH-bit signed range, and
//               ovf flags a clamped result.
//   undefined : the final narrowing keeps the low WIDTH bits (two's-complement
//               wrap), and ovf is tied to 0.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   start      in   1      begin a run; sampled only in IDLE
//   len        in   LEN_W  number of products in the run; sampled with start
//   p_valid    in   1      product p is valid
//   p          in   WIDTH  signed Q17.15 product
//   p_ready    out  1      accumulator accepts p this cycle
//   busy       out  1      high in ACC and HOLD
//   sum_valid  out  1      sum is valid
//   sum        out  WIDTH  signed Q17.15 dot-product result
//   sum_ready  in   1      consumer accepts sum
//   ovf        out  1      final sum was clamped; valid with sum_valid
// -----------------------------------------------------------------------------
module dot_accumulator #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8,
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        len,
  input  logic                    p_valid,
  input  logic signed [WIDTH-1:0] p,
  output logic                    p_ready,
  output logic                    busy,
  output logic                    sum_valid,
  output logic signed [WIDTH-1:0] sum,
  input  logic                    sum_ready,
  output logic                    ovf
);

  localparam int ACC_W = WIDTH + GUARD;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] ACC  = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;

`ifdef DOT_ACC_SAT_EN
  // WIDTH-bit signed limits, sign-extended to the accumulator width.
  localparam logic signed [ACC_W-1:0] MAX_EXT = {{(GUARD+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_EXT = {{(GUARD+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic overflow_f(input logic signed [ACC_W-1:0] v);
    return (v > MAX_EXT) || (v < MIN_EXT);
  endfunction

  function automatic logic signed [WIDTH-1:0] narrow_f(input logic signed [ACC_W-1:0] v);
    if (v > MAX_EXT) begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end else if (v < MIN_EXT) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      return v[WIDTH-1:0];
    end
  endfunction
`else
  function automatic logic signed [WIDTH-1:0] narrow_f(input logic signed [ACC_W-1:0] v);
    return v[WIDTH-1:0];
  endfunction
`endif

  logic [1:0]               state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]         cnt_q, cnt_d;
  logic signed [WIDTH-1:0]  sum_q, sum_d;
  logic                     ovf_q, ovf_d;
  logic signed [ACC_W-1:0]  acc_sum;

  // Running total including the product offered this cycle; it is also the
  // final value on the last transfer, so the result needs no extra cycle.
  assign acc_sum = acc_q + {{GUARD{p[WIDTH-1]}}, p};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            acc_d   = '0;
            cnt_d   = len;
            state_d = ACC;
          end else begin
            // Empty run: the dot product is zero and goes straight out.
            sum_d   = '0;
            ovf_d   = 1'b0;
            state_d = HOLD;
          end
        end
      end
      ACC: begin
        if (p_valid) begin
          acc_d = acc_sum;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) begin
            sum_d   = narrow_f(acc_sum);
`ifdef DOT_ACC_SAT_EN
            ovf_d   = overflow_f(acc_sum);
`else
            ovf_d   = 1'b0;
`endif
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (sum_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p_ready   = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign sum_valid = (state_q == HOLD);
  assign sum       = sum_q;
  // ovf is only meaningful alongside sum_valid.
  assign ovf       = ovf_q & sum_valid;

endmodule

// File: tb/tb_dot_accumulator.sv
module tb_dot_accumulator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [7:0]         len = '0;
  logic               p_valid = 1'b0;
  logic signed [31:0] p = '0;
  logic               p_ready;
  logic               busy;
  logic               sum_valid;
  logic signed [31:0] sum;
  logic               sum_ready = 1'b0;
  logic               ovf;

  int checks = 0;
  int errors = 0;

  logic [31:0] pq[$];

  dot_accumulator #(.WIDTH(32), .GUARD(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .p_valid(p_valid), .p(p), .p_ready(p_ready), .busy(busy),
    .sum_valid(sum_valid), .sum(sum), .sum_ready(sum_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: sum with unbounded integer arithmetic, then narrow.
  task automatic model(output logic [31:0] s, output logic o);
    longint t;
    t = 0;
    foreach (pq[i]) t += longint'($signed(pq[i]));
`ifdef DOT_ACC_SAT_EN
    if (t > 64'sd2147483647) begin
      s = 32'h7FFFFFFF; o = 1'b1;
    end else if (t < -64'sd2147483648) begin
      s = 32'h80000000; o = 1'b1;
    end else begin
      s = t[31:0]; o = 1'b0;
    end
`else
    s = t[31:0]; o = 1'b0;
`endif
  endtask

  // Runs one dot product of the products in pq, with 'gap' bubbles between
  // products and 'hold' cycles of back-pressure, then releases the result.
  task automatic run(input string nm, input int gap, input int hold, input bit pulse_start,
                     input logic [31:0] esum, input logic eovf);
    int n;
    n = pq.size();
    @(negedge clk);
    start = 1'b1;
    len   = 8'(n);
    @(negedge clk);
    start = 1'b0;
    len   = 8'hA5;
    if (n == 0) begin
      p_valid = 1'b1;  // must not be taken
      p       = 32'h12345678;
    end
    for (int i = 0; i < n; i++) begin
      check({nm, "/p_ready"}, 32'(p_ready), 32'd1);
      p_valid = 1'b1;
      p       = pq[i];
      @(negedge clk);
      p_valid = 1'b0;
      p       = 32'hDEADBEEF;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          check({nm, "/bubble_p_ready"}, 32'(p_ready), 32'd1);
          check({nm, "/bubble_valid"}, 32'(sum_valid), 32'd0);
          @(negedge clk);
        end
      end
    end
    check({nm, "/sum_valid"}, 32'(sum_valid), 32'd1);
    check({nm, "/p_ready_hold"}, 32'(p_ready), 32'd0);
    check({nm, "/sum"}, sum, esum);
    check({nm, "/ovf"}, 32'(ovf), 32'(eovf));
    p_valid = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start = pulse_start & h[0];
      len   = 8'd3;
      @(negedge clk);
      check({nm, "/hold_valid"}, 32'(sum_valid), 32'd1);
      check({nm, "/hold_sum"}, sum, esum);
      check({nm, "/hold_ovf"}, 32'(ovf), 32'(eovf));
    end
    start     = 1'b0;
    sum_ready = 1'b1;
    @(negedge clk);
    sum_ready = 1'b0;
    check({nm, "/released_valid"}, 32'(sum_valid), 32'd0);
    check({nm, "/released_busy"}, 32'(busy), 32'd0);
    check({nm, "/sum_kept"}, sum, esum);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [31:0] pv[3];
    int          gap;
    logic [31:0] exp_sum;
    logic        exp_ovf;
  } vec_t;

  vec_t vt[3];

  initial begin
    logic [31:0] es;
    logic        eo;

    vt[0] = '{"t1_three_tens", 3, '{32'h00050000, 32'h00050000, 32'h00050000}, 0, 32'h000F0000, 1'b0};
    vt[1] = '{"t2_bubbles", 2, '{32'hFFFF4000, 32'h00004000, 32'h0}, 4, 32'hFFFF8000, 1'b0};
`ifdef DOT_ACC_SAT_EN
    vt[2] = '{"t3_overflow", 2, '{32'h7FFF0000, 32'h7FFF0000, 32'h0}, 0, 32'h7FFFFFFF, 1'b1};
`else
    vt[2] = '{"t3_overflow", 2, '{32'h7FFF0000, 32'h7FFF0000, 32'h0}, 0, 32'hFFFE0000, 1'b0};
`endif

    // Reset state
    @(negedge clk);
    check("rst/p_ready", 32'(p_ready), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/sum_valid", 32'(sum_valid), 32'd0);
    check("rst/sum", sum, 32'd0);
    check("rst/ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle/busy", 32'(busy), 32'd0);

    for (int v = 0; v < 3; v++) begin
      pq.delete();
      for (int i = 0; i < vt[v].n; i++) pq.push_back(vt[v].pv[i]);
      run(vt[v].name, vt[v].gap, 0, 1'b0, vt[v].exp_sum, vt[v].exp_ovf);
    end

    // len == 0: immediate zero result, no transfers
    pq.delete();
    run("t4_len0", 0, 0, 1'b0, 32'h0, 1'b0);

    // Back-pressure with ignored start pulses
    pq.delete();
    pq.push_back(32'h00018000);
    pq.push_back(32'h00020000);
    run("t5_hold", 0, 10, 1'b1, 32'h00038000, 1'b0);

    // Reset mid-run abandons the run
    @(negedge clk);
    start = 1'b1;
    len   = 8'd3;
    @(negedge clk);
    start   = 1'b0;
    p_valid = 1'b1;
    p       = 32'h00050000;
    @(negedge clk);
    p_valid = 1'b0;
    check("t6/busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6/rst_busy", 32'(busy), 32'd0);
    check("t6/rst_p_ready", 32'(p_ready), 32'd0);
    check("t6/rst_sum_valid", 32'(sum_valid), 32'd0);
    check("t6/rst_sum", sum, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pq.delete();
    pq.push_back(32'h00008000);
    run("t6_after_rst", 0, 0, 1'b0, 32'h00008000, 1'b0);

    // Randomized runs against the reference model
    for (int r = 0; r < 25; r++) begin
      int n;
      n = int'($urandom_range(1, 8));
      pq.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: pq.push_back(32'h7FFF0000 + $urandom_range(0, 65535));
          1: pq.push_back(32'h80000000 + $urandom_range(0, 65535));
          default: pq.push_back($urandom);
        endcase
      end
      model(es, eo);
      run($sformatf("rand%0d", r), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
          1'b1, es, eo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
